// File: rtl/jpeg_transpose_buffer.sv
// 64-word block buffer: any-order writes, LANES-wide beats out (transposed or pass-through).
// First beat 2 edges after the index-63 write; accept drops only when every buffer is full.
module jpeg_transpose_buffer #(
  parameter int DATA_W   = 32,
  parameter int NUM_BUFS = 2,
  parameter int LANES    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    img_start_i,
  input  logic                    mode_i,
  input  logic                    inport_valid_i,
  output logic                    inport_accept_o,
  input  logic [DATA_W-1:0]       inport_data_i,
  input  logic [5:0]              inport_idx_i,
  output logic                    outport_valid_o,
  input  logic                    outport_ready_i,
  output logic [LANES*DATA_W-1:0] outport_data_o,
  output logic [5:0]              outport_idx_o,
  output logic                    outport_last_o,
  output logic [2:0]              level_o
);
  localparam int PTR_W = (NUM_BUFS > 2) ? 2 : 1;
  localparam int BEATS = 64 / LANES;
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NUM_BUFS - 1);
  localparam logic [5:0]       BEAT_MAX = 6'(BEATS - 1);

  logic [DATA_W-1:0]       mem_q [NUM_BUFS][64];
  logic [NUM_BUFS-1:0]     full_q, full_d, seen_q, mode_q;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [5:0]              beat_q;
  logic [5:0]              k, src;
  logic                    wr_fire, blk_done, avail, issue, xfer, free_buf;
  logic [LANES*DATA_W-1:0] beat_dat;

  assign inport_accept_o = !full_q[wr_ptr_q];
  assign wr_fire  = inport_valid_i && inport_accept_o;
  assign blk_done = wr_fire && (inport_idx_i == 6'd63);
  assign xfer     = outport_valid_o && outport_ready_i;
  assign free_buf = xfer && outport_last_o;
  // seen_q trails full_q by one edge, giving the fixed two-edge start latency; the next
  // block waits until the previous last beat has left so its buffer is freed first.
  assign avail = full_q[rd_ptr_q] && seen_q[rd_ptr_q] && !(outport_valid_o && outport_last_o);
  assign issue = avail && (!outport_valid_o || outport_ready_i);

  always_comb begin
    full_d = full_q;
    if (blk_done) full_d[wr_ptr_q] = 1'b1;
    if (free_buf) full_d[rd_ptr_q] = 1'b0;
  end

  always_comb begin
    beat_dat = '0;
    k        = '0;
    src      = '0;
    for (int l = 0; l < LANES; l++) begin
      k   = 6'(int'(beat_q) * LANES + l);
      src = mode_q[rd_ptr_q] ? {k[2:0], k[5:3]} : k;
      beat_dat[l*DATA_W +: DATA_W] = mem_q[rd_ptr_q][src];
    end
  end

  always_comb begin
    level_o = '0;
    for (int b = 0; b < NUM_BUFS; b++) level_o = level_o + {2'b00, full_q[b]};
  end

  // Storage and the output data word carry no reset; validity lives in the control flops.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q][inport_idx_i] <= inport_data_i;
    if (issue) outport_data_o <= beat_dat;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      full_q          <= '0;
      seen_q          <= '0;
      mode_q          <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      beat_q          <= '0;
      outport_valid_o <= 1'b0;
      outport_last_o  <= 1'b0;
      outport_idx_o   <= '0;
    end else if (img_start_i) begin
      full_q          <= '0;
      seen_q          <= '0;
      mode_q          <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      beat_q          <= '0;
      outport_valid_o <= 1'b0;
      outport_last_o  <= 1'b0;
      outport_idx_o   <= '0;
    end else begin
      full_q <= full_d;
      seen_q <= full_q & full_d;
      if (blk_done) begin
        mode_q[wr_ptr_q] <= mode_i;
        wr_ptr_q         <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (free_buf) rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
      if (issue) begin
        outport_valid_o <= 1'b1;
        outport_idx_o   <= beat_q;
        outport_last_o  <= (beat_q == BEAT_MAX);
        beat_q          <= (beat_q == BEAT_MAX) ? '0 : beat_q + 6'd1;
      end else if (xfer) begin
        outport_valid_o <= 1'b0;
        outport_last_o  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_jpeg_transpose_buffer.sv
// Bench for jpeg_transpose_buffer: block-level reference model predicts every beat, level and
// accept; literal expectations pin the model on known blocks.
module tb_jpeg_transpose_buffer;
  localparam int DW = 32;
  localparam int NB = 2;
  localparam int LN = 4;
  localparam int BW = DW * LN;

  typedef struct {
    logic [BW-1:0] dat;
    logic [5:0]    idx;
    logic          last;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_i, img_start_i, mode_i, inport_valid_i, inport_accept_o;
  logic [DW-1:0] inport_data_i;
  logic [5:0]    inport_idx_i;
  logic          outport_valid_o, outport_ready_i;
  logic [BW-1:0] outport_data_o;
  logic [5:0]    outport_idx_o;
  logic          outport_last_o;
  logic [2:0]    level_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat_c = -100;
  int first_c = 0;
  int last_c = 0;
  int mlevel = 0;
  int rdy_mode = 0;
  int base = 0;
  beat_t exp_q[$];
  beat_t cap_q[$];
  logic [DW-1:0] blk_m [64];

  always #5 clk_i = ~clk_i;

  jpeg_transpose_buffer #(.DATA_W(DW), .NUM_BUFS(NB), .LANES(LN)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .img_start_i(img_start_i), .mode_i(mode_i),
    .inport_valid_i(inport_valid_i), .inport_accept_o(inport_accept_o),
    .inport_data_i(inport_data_i), .inport_idx_i(inport_idx_i),
    .outport_valid_o(outport_valid_o), .outport_ready_i(outport_ready_i),
    .outport_data_o(outport_data_o), .outport_idx_o(outport_idx_o),
    .outport_last_o(outport_last_o), .level_o(level_o)
  );

  task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Expected beats from the block contents using the element mapping directly.
  task automatic push_block(input logic md);
    for (int j = 0; j < 64 / LN; j++) begin
      beat_t b;
      b.dat = '0;
      for (int l = 0; l < LN; l++) begin
        int kk;
        int sr;
        kk = j * LN + l;
        sr = md ? (kk % 8) * 8 + kk / 8 : kk;
        b.dat[l*DW +: DW] = blk_m[sr];
      end
      b.idx  = 6'(j);
      b.last = (j == 64 / LN - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic monitor();
    beat_t pb;
    beat_t got;
    logic  p_stall;
    logic  acc_m;
    p_stall = 1'b0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_i) begin
        exp_q.delete();
        mlevel  = 0;
        lat_c   = -100;
        p_stall = 1'b0;
        chk("rst_level", BW'(level_o), '0);
        chk("rst_valid", BW'(outport_valid_o), '0);
        chk("rst_last", BW'(outport_last_o), '0);
        chk("rst_idx", BW'(outport_idx_o), '0);
        chk("rst_accept", BW'(inport_accept_o), BW'(1));
      end else begin
        acc_m = (mlevel < NB);
        chk("level", BW'(level_o), BW'(mlevel));
        chk("accept", BW'(inport_accept_o), BW'(acc_m));
        if (cyc == lat_c + 2) chk("latency_early", BW'(outport_valid_o), '0);
        if (cyc == lat_c + 3) chk("latency_rise", BW'(outport_valid_o), BW'(1));
        if (p_stall) begin
          chk("hold_valid", BW'(outport_valid_o), BW'(1));
          chk("hold_data", outport_data_o, pb.dat);
          chk("hold_idx", BW'(outport_idx_o), BW'(pb.idx));
          chk("hold_last", BW'(outport_last_o), BW'(pb.last));
        end
        if (exp_q.size() == 0) chk("spurious_valid", BW'(outport_valid_o), '0);
        if (img_start_i) begin
          exp_q.delete();
          mlevel  = 0;
          lat_c   = -100;
          p_stall = 1'b0;
        end else begin
          if (outport_valid_o && outport_ready_i && exp_q.size() > 0) begin
            got.dat  = outport_data_o;
            got.idx  = outport_idx_o;
            got.last = outport_last_o;
            cap_q.push_back(got);
            chk("beat_data", got.dat, exp_q[0].dat);
            chk("beat_idx", BW'(got.idx), BW'(exp_q[0].idx));
            chk("beat_last", BW'(got.last), BW'(exp_q[0].last));
            if (exp_q[0].idx == 6'd0) first_c = cyc;
            if (exp_q[0].last) begin
              last_c = cyc;
              mlevel--;
            end
            void'(exp_q.pop_front());
          end
          p_stall  = outport_valid_o && !outport_ready_i;
          pb.dat   = outport_data_o;
          pb.idx   = outport_idx_o;
          pb.last  = outport_last_o;
          if (inport_valid_i && acc_m) begin
            blk_m[inport_idx_i] = inport_data_i;
            if (inport_idx_i == 6'd63) begin
              if (exp_q.size() == 0) lat_c = cyc;
              push_block(mode_i);
              mlevel++;
            end
          end
        end
      end
    end
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk_i);
      #2;
      case (rdy_mode)
        0:       outport_ready_i = 1'b0;
        1:       outport_ready_i = 1'b1;
        default: outport_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  task automatic do_write(input logic [5:0] idx, input logic [DW-1:0] dat, input logic md);
    int   n;
    logic ok;
    n = 0;
    inport_valid_i = 1'b1;
    inport_idx_i   = idx;
    inport_data_i  = dat;
    mode_i         = md;
    forever begin
      @(negedge clk_i);
      ok = inport_accept_o;
      @(posedge clk_i);
      #1;
      if (ok) break;
      n++;
      if (n > 3000) begin
        total++;
        bad++;
        $display("FAIL write_timeout idx=%0d", idx);
        break;
      end
    end
  endtask

  task automatic write_blk(input logic md, input bit ordered, input int vbase, input bit bubbles);
    int ord[63];
    for (int i = 0; i < 63; i++) ord[i] = i;
    if (!ordered) begin
      for (int i = 62; i > 0; i--) begin
        int j;
        int t;
        j = int'($urandom_range(0, i));
        t = ord[i];
        ord[i] = ord[j];
        ord[j] = t;
      end
    end
    for (int i = 0; i < 63; i++) begin
      if (bubbles && $urandom_range(0, 3) == 0) begin
        inport_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
      end
      do_write(6'(ord[i]), ordered ? DW'(vbase + ord[i]) : $urandom, md);
    end
    if (!ordered) repeat (2) do_write(6'($urandom_range(0, 62)), $urandom, md);
    do_write(6'd63, ordered ? DW'(vbase + 63) : $urandom, md);
    inport_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout left=%0d", exp_q.size());
    end
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    img_start_i = 1'b0;
    mode_i = 1'b0;
    inport_valid_i = 1'b0;
    inport_data_i = '0;
    inport_idx_i = '0;
    outport_ready_i = 1'b0;
    fork
      monitor();
      drive_ready();
      begin
        #2000000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
      end
    join_none
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // Transpose, value = index, ready high.
    rdy_mode = 1;
    base = cap_q.size();
    write_blk(1'b1, 1'b1, 0, 1'b0);
    drain();
    chk("t1_beat0", cap_q[base].dat, {32'd24, 32'd16, 32'd8, 32'd0});
    chk("t1_beat15", cap_q[base+15].dat, {32'd63, 32'd55, 32'd47, 32'd39});
    chk("t1_last15", BW'(cap_q[base+15].last), BW'(1));
    chk("t1_idx15", BW'(cap_q[base+15].idx), BW'(15));
    chk("t1_no_bubble", BW'(last_c - first_c), BW'(15));

    // Pass-through, same stimulus.
    base = cap_q.size();
    write_blk(1'b0, 1'b1, 0, 1'b0);
    drain();
    chk("t2_beat0", cap_q[base].dat, {32'd3, 32'd2, 32'd1, 32'd0});
    chk("t2_beat5", cap_q[base+5].dat, {32'd23, 32'd22, 32'd21, 32'd20});
    chk("t2_no_bubble", BW'(last_c - first_c), BW'(15));

    // Both buffers full with ready low; third block stalls until the first drains.
    rdy_mode = 0;
    base = cap_q.size();
    write_blk(1'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
    write_blk(1'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("t3_level_full", BW'(level_o), BW'(2));
    chk("t3_accept_low", BW'(inport_accept_o), '0);
    chk("t3_valid_waiting", BW'(outport_valid_o), BW'(1));
    @(posedge clk_i);
    #1;
    fork
      begin
        repeat (20) @(posedge clk_i);
        rdy_mode = 1;
      end
    join_none
    write_blk(1'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
    drain();
    chk("t3_beats", BW'(cap_q.size() - base), BW'(48));

    // Completion of block B lands on the same edge as block A's last beat.
    rdy_mode = 0;
    write_blk(1'b1, 1'b1, 200, 1'b0);
    for (int i = 0; i < 63; i++) do_write(6'(i), DW'(300 + i), 1'b0);
    inport_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rdy_mode = 1;
    repeat (15) @(posedge clk_i);
    #1;
    inport_valid_i = 1'b1;
    inport_idx_i = 6'd63;
    inport_data_i = DW'(363);
    mode_i = 1'b0;
    @(negedge clk_i);
    chk("t4_coincide", BW'(outport_valid_o && outport_last_o && outport_ready_i), BW'(1));
    chk("t4_accept_before", BW'(inport_accept_o), BW'(1));
    @(posedge clk_i);
    #1;
    inport_valid_i = 1'b0;
    @(negedge clk_i);
    chk("t4_level_after", BW'(level_o), BW'(1));
    chk("t4_accept_after", BW'(inport_accept_o), BW'(1));
    drain();

    // 100 random blocks, random order/mode/bubbles, random ready.
    rdy_mode = 2;
    base = cap_q.size();
    for (int b = 0; b < 100; b++) write_blk(1'($urandom_range(0, 1)), 1'b0, 0, 1'b1);
    drain();
    chk("t5_beats", BW'(cap_q.size() - base), BW'(1600));

    // Flush mid-readout, then reset mid-block, then a clean block.
    write_blk(1'b1, 1'b0, 0, 1'b0);
    repeat (6) @(posedge clk_i);
    #1;
    img_start_i = 1'b1;
    @(posedge clk_i);
    #1;
    img_start_i = 1'b0;
    @(negedge clk_i);
    chk("t6_flush_valid", BW'(outport_valid_o), '0);
    chk("t6_flush_level", BW'(level_o), '0);
    @(posedge clk_i);
    #1;
    rdy_mode = 0;
    write_blk(1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 30; i++) do_write(6'(i), $urandom, 1'b1);
    inport_valid_i = 1'b0;
    #3;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("t6_rst_valid", BW'(outport_valid_o), '0);
    chk("t6_rst_level", BW'(level_o), '0);
    chk("t6_rst_accept", BW'(inport_accept_o), BW'(1));
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    rdy_mode = 1;
    base = cap_q.size();
    write_blk(1'b1, 1'b1, 100, 1'b0);
    drain();
    chk("t6_beat0", cap_q[base].dat, {32'd124, 32'd116, 32'd108, 32'd100});
    chk("t6_beat15", cap_q[base+15].dat, {32'd163, 32'd155, 32'd147, 32'd139});
    chk("t6_beats", BW'(cap_q.size() - base), BW'(16));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jpeg_transpose_buffer.md
JPEG_TRANSPOSE_BUFFER -- requirements
Module: jpeg_transpose_buffer

Interface
REQ-001 Parameter DATA_W, default 32: coefficient word width.
REQ-002 Parameter NUM_BUFS, default 2: number of 64-entry block buffers; legal values 2..4.
REQ-003 Parameter LANES, default 4: words per output beat; legal values 1, 2, 4, 8.
REQ-004 Port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_i, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port img_start_i, input, 1: synchronous flush of all buffers and read state.
REQ-007 Port mode_i, input, 1: 1 = transpose, 0 = pass-through; sampled with the index-63 write.
REQ-008 Ports inport_valid_i, input, 1, and inport_accept_o, output, 1: input handshake.
REQ-009 Port inport_data_i, input, DATA_W: coefficient.
REQ-010 Port inport_idx_i, input, 6: row-major position 0..63 within the block.
REQ-011 Ports outport_valid_o, output, 1, and outport_ready_i, input, 1: output handshake.
REQ-012 Port outport_data_o, output, LANES*DATA_W: lane L occupies bits [L*DATA_W +: DATA_W].
REQ-013 Port outport_idx_o, output, 6: beat number within the block, 0..64/LANES-1.
REQ-014 Port outport_last_o, output, 1: high on the final beat of a block.
REQ-015 Port level_o, output, 3: number of full buffers awaiting or under readout.

Function
REQ-016 A write occurs when inport_valid_i && inport_accept_o; it stores inport_data_i at inport_idx_i in the current write buffer.
REQ-017 Writes may arrive in any index order; a repeated index overwrites the earlier value.
REQ-018 A write with index 63 completes the block: the buffer is marked full, mode_i is latched for it, and the write pointer advances modulo NUM_BUFS.
REQ-019 inport_accept_o SHALL be high iff the current write buffer is not full, i.e. level_o < NUM_BUFS.
REQ-020 Buffers are read in completion order, oldest first.
REQ-021 Output element k (0..63) maps as follows: transpose mode, source index (k%8)*8 + k/8; pass-through mode, source index k.
REQ-022 Beat j carries output elements j*LANES+L on lane L.
REQ-023 A beat transfers on outport_valid_o && outport_ready_i.
REQ-024 While outport_valid_o is high and outport_ready_i is low, outport_data_o, outport_idx_o and outport_last_o SHALL hold stable.
REQ-025 outport_valid_o SHALL NOT drop until the beat transfers.
REQ-026 With outport_ready_i held high, one beat transfers per cycle with no bubbles within a block.
REQ-027 Between consecutive ready blocks there is at most one idle cycle.
REQ-028 Latency: with the output idle, outport_valid_o rises exactly 2 rising edges after the edge that accepts index 63.
REQ-029 When the last beat transfers, the buffer is freed, the read pointer advances modulo NUM_BUFS, and the beat counter returns to 0.
REQ-030 If a block completes and another is freed in the same cycle, both take effect and level_o is unchanged.
REQ-031 A completion when level_o == NUM_BUFS-1 and a simultaneous free SHALL NOT deassert inport_accept_o in the next cycle.
REQ-032 img_start_i has priority over all other events: next cycle level_o=0, both pointers=0, beat counter=0, outport_valid_o=0, and any in-flight beat is discarded.
REQ-033 Buffer storage contents are not cleared by reset or flush; only validity state is cleared.

Reset
REQ-034 On rst_i low, asynchronously: level_o=0, outport_valid_o=0, outport_last_o=0, outport_idx_o=0, pointers=0, inport_accept_o=1 once control state is cleared; outport_data_o is don't-care.
REQ-035 Deassertion of rst_i SHALL be synchronous to clk_i; the first write may be accepted on the first edge after deassertion.
REQ-036 Reset asserted mid-block discards all partial and full blocks.

Verification
REQ-037 Transpose, LANES=4, ready high: write value = index for indices 0..63 -> beat 0 lanes {0,8,16,24}, beat 15 lanes {39,47,55,63} with outport_last_o=1, 16 consecutive beats, first beat exactly 2 edges after index 63 is accepted.
REQ-038 Pass-through, LANES=8: same stimulus -> beat j lanes = 8j..8j+7, beats 0..7.
REQ-039 NUM_BUFS=2, ready low: write 2 blocks -> level_o=2, inport_accept_o=0; a third block's writes are stalled; raise ready -> blocks emerge in order, accept reasserts after block 1's last beat.
REQ-040 Random outport_ready_i toggling -> data and idx stable while stalled, no beat lost or duplicated over 100 blocks with random write order and random mode_i.
REQ-041 Last write of block N+1 coincides with last beat of block N -> level_o unchanged, no accept glitch.
REQ-042 Assert img_start_i mid-readout, then assert rst_i low mid-block -> outputs return to reset values; the next block reads out correctly.
